// File: rtl/mem_access_unit_pkg.sv
// Shared memory-stage types for the MIPS pipeline (package CPU_def).
// Access-size and memory-access-unit state encodings used by mem_access_unit and lane_align.
package CPU_def;

    localparam int unsigned BYTE_LANES = 4;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        MAU_IDLE,
        MAU_REQ,
        MAU_WAIT,
        MAU_DONE
    } mau_state_t;

    // Size code 2'b11 is treated as a word access.
    function automatic mem_size_t decode_size(input logic [1:0] code);
        case (code)
            2'b00:   return MEM_BYTE;
            2'b01:   return MEM_HALF;
            default: return MEM_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// lane_align: little-endian byte-lane steering for stores and load extraction.
// Purely combinational; data width is fixed at four byte lanes.
module lane_align
    import CPU_def::*;
#(
    parameter int unsigned DATA_BITS = 32
) (
    input  logic [1:0]            offset,
    input  mem_size_t             size,
    input  logic                  is_unsigned,
    input  logic [DATA_BITS-1:0]  wdata,
    input  logic [DATA_BITS-1:0]  rdata,
    output logic [BYTE_LANES-1:0] be,
    output logic [DATA_BITS-1:0]  wdata_rep,
    output logic [DATA_BITS-1:0]  rdata_ext
);

    logic [DATA_BITS-1:0] shifted;

    always_comb begin
        be        = '0;
        wdata_rep = '0;
        rdata_ext = '0;
        shifted   = rdata >> {offset, 3'b000};
        case (size)
            MEM_BYTE: begin
                be        = 4'b0001 << offset;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = is_unsigned ? {{(DATA_BITS-8){1'b0}}, shifted[7:0]}
                                        : {{(DATA_BITS-8){shifted[7]}}, shifted[7:0]};
            end
            MEM_HALF: begin
                be        = 4'b0011 << {offset[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = is_unsigned ? {{(DATA_BITS-16){1'b0}}, shifted[15:0]}
                                        : {{(DATA_BITS-16){shifted[15]}}, shifted[15:0]};
            end
            default: begin
                be        = '1;
                wdata_rep = wdata;
                rdata_ext = shifted;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: M-stage load/store initiator on a valid/ready data-memory channel.
// Optional macro MEM_MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of aligning them.
module mem_access_unit
    import CPU_def::*;
#(
    parameter int unsigned ADDR_BITS      = 32,
    parameter int unsigned DATA_BITS      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_read_m,
    input  logic                 mem_write_m,
    input  logic [1:0]           mem_size_m,
    input  logic                 mem_unsigned_m,
    input  logic [ADDR_BITS-1:0] alu_out_m,
    input  logic [DATA_BITS-1:0] write_data_m,
    output logic                 stall_m,
    output logic [DATA_BITS-1:0] read_data_m,
    output logic                 load_valid_m,
    output logic                 misalign_m,
    output logic                 bus_error_m,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [ADDR_BITS-3:0] dmem_addr,
    output logic [3:0]           dmem_be,
    output logic [DATA_BITS-1:0] dmem_wdata,
    input  logic                 dmem_ready,
    input  logic                 dmem_rvalid,
    input  logic [DATA_BITS-1:0] dmem_rdata
);

    localparam int unsigned CNT_BITS = $clog2(TIMEOUT_CYCLES + 1);

    mau_state_t state, state_nxt;

    logic [ADDR_BITS-3:0] waddr_q;
    logic [1:0]           offset_q;
    mem_size_t            size_q;
    logic                 uns_q;
    logic                 we_q;
    logic                 err_q;
    logic [DATA_BITS-1:0] wdata_q;
    logic [DATA_BITS-1:0] rdata_q;
    logic [CNT_BITS-1:0]  cnt_q;

    mem_size_t            size_in;
    logic [1:0]           offset_in;
    logic                 start;
    logic                 trap;
    logic                 expired;
    logic                 to_err;
    logic [3:0]           be_w;
    logic [DATA_BITS-1:0] wdata_w;
    logic [DATA_BITS-1:0] rdata_w;

`ifdef MEM_MISALIGN_TRAP_EN
    logic mis_q;
    assign trap = ((size_in == MEM_HALF) && alu_out_m[0]) ||
                  ((size_in == MEM_WORD) && (alu_out_m[1:0] != 2'b00));
`else
    assign trap = 1'b0;
`endif

    // Offset is always forced to natural alignment; trapped accesses never use it.
    always_comb begin
        size_in = decode_size(mem_size_m);
        case (size_in)
            MEM_BYTE: offset_in = alu_out_m[1:0];
            MEM_HALF: offset_in = {alu_out_m[1], 1'b0};
            default:  offset_in = 2'b00;
        endcase
    end

    always_comb begin
        start     = (state == MAU_IDLE) && (mem_read_m || mem_write_m) && !rst;
        expired   = (cnt_q == CNT_BITS'(TIMEOUT_CYCLES - 1));
        to_err    = 1'b0;
        state_nxt = state;
        case (state)
            MAU_IDLE: if (start) state_nxt = trap ? MAU_DONE : MAU_REQ;
            MAU_REQ: begin
                if (dmem_ready) begin
                    state_nxt = we_q ? MAU_DONE : MAU_WAIT;
                end else if (expired) begin
                    state_nxt = MAU_DONE;
                    to_err    = 1'b1;
                end
            end
            MAU_WAIT: begin
                if (dmem_rvalid) begin
                    state_nxt = MAU_DONE;
                end else if (expired) begin
                    state_nxt = MAU_DONE;
                    to_err    = 1'b1;
                end
            end
            default: state_nxt = MAU_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= MAU_IDLE;
            waddr_q  <= '0;
            offset_q <= '0;
            size_q   <= MEM_BYTE;
            uns_q    <= 1'b0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state <= state_nxt;
            if ((state == MAU_REQ) || (state == MAU_WAIT)) cnt_q <= cnt_q + 1'b1;
            else                                          cnt_q <= '0;
            if (start) begin
                waddr_q  <= alu_out_m[ADDR_BITS-1:2];
                offset_q <= offset_in;
                size_q   <= size_in;
                uns_q    <= mem_unsigned_m;
                we_q     <= mem_write_m;
                wdata_q  <= write_data_m;
                err_q    <= 1'b0;
            end
            if ((state == MAU_WAIT) && dmem_rvalid) begin
                rdata_q <= rdata_w;
            end else if (to_err) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end else if (start && trap) begin
                rdata_q <= '0;
            end
        end
    end

    lane_align #(
        .DATA_BITS(DATA_BITS)
    ) u_lane_align (
        .offset      (offset_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .rdata       (dmem_rdata),
        .be          (be_w),
        .wdata_rep   (wdata_w),
        .rdata_ext   (rdata_w)
    );

    always_comb begin
        dmem_req     = (state == MAU_REQ);
        dmem_we      = dmem_req && we_q;
        dmem_addr    = dmem_req ? waddr_q : '0;
        dmem_be      = dmem_req ? be_w    : '0;
        dmem_wdata   = dmem_req ? wdata_w : '0;
        stall_m      = start || (state == MAU_REQ) || (state == MAU_WAIT);
        read_data_m  = rdata_q;
        bus_error_m  = (state == MAU_DONE) && err_q;
        load_valid_m = (state == MAU_DONE) && !we_q && !err_q && !trap_done();
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        mis_q <= 1'b0;
        else if (start) mis_q <= trap;
    end

    function automatic logic trap_done();
        return mis_q;
    endfunction

    assign misalign_m = (state == MAU_DONE) && mis_q;
`else
    function automatic logic trap_done();
        return 1'b0;
    endfunction

    assign misalign_m = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: transaction-level model predicts every output per cycle.
// Honours MEM_MISALIGN_TRAP_EN when the design is built with it.
module tb_mem_access_unit;

    localparam int TMO = 255;

    logic        clk;
    logic        rst;
    logic        mem_read_m;
    logic        mem_write_m;
    logic [1:0]  mem_size_m;
    logic        mem_unsigned_m;
    logic [31:0] alu_out_m;
    logic [31:0] write_data_m;
    logic        stall_m;
    logic [31:0] read_data_m;
    logic        load_valid_m;
    logic        misalign_m;
    logic        bus_error_m;
    logic        dmem_req;
    logic        dmem_we;
    logic [29:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    mem_access_unit #(
        .ADDR_BITS(32),
        .DATA_BITS(32),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .mem_read_m(mem_read_m), .mem_write_m(mem_write_m), .mem_size_m(mem_size_m),
        .mem_unsigned_m(mem_unsigned_m), .alu_out_m(alu_out_m), .write_data_m(write_data_m),
        .stall_m(stall_m), .read_data_m(read_data_m), .load_valid_m(load_valid_m),
        .misalign_m(misalign_m), .bus_error_m(bus_error_m),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Per-cycle expectations, written by the stimulus at posedge+1 and compared at negedge.
    bit          chk_en;
    bit          exp_stall, exp_req, exp_we, exp_lv, exp_berr, exp_mis;
    logic [29:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata, exp_rd, rd_model;

    logic [29:0] cap_addr;
    logic [3:0]  cap_be;
    logic [31:0] cap_wdata, cap_rd;
    bit          cap_req, cap_berr, cap_mis;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int nb(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [3:0] m_be(input int k0, input int n);
        logic [3:0] b;
        for (int i = 0; i < 4; i++) b[i] = (i >= k0) && (i < k0 + n);
        return b;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] wd, input int n);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rdat, input int k0, input int n, input bit uns);
        longint v;
        v = 0;
        for (int j = 0; j < n; j++) v = v + (longint'({24'b0, rdat[8*(k0+j) +: 8]}) << (8*j));
        if (!uns && n < 4 && v >= (longint'(1) << (8*n - 1))) v = v - (longint'(1) << (8*n));
        return v[31:0];
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall_m", {31'b0, stall_m}, {31'b0, exp_stall});
            chk("dmem_req", {31'b0, dmem_req}, {31'b0, exp_req});
            if (exp_req) begin
                chk("dmem_we", {31'b0, dmem_we}, {31'b0, exp_we});
                chk("dmem_addr", {2'b0, dmem_addr}, {2'b0, exp_addr});
                chk("dmem_be", {28'b0, dmem_be}, {28'b0, exp_be});
                if (exp_we) chk("dmem_wdata", dmem_wdata, exp_wdata);
            end
            chk("load_valid_m", {31'b0, load_valid_m}, {31'b0, exp_lv});
            chk("bus_error_m", {31'b0, bus_error_m}, {31'b0, exp_berr});
            chk("misalign_m", {31'b0, misalign_m}, {31'b0, exp_mis});
            chk("read_data_m", read_data_m, exp_rd);
            if (dmem_req) begin
                cap_req = 1'b1; cap_addr = dmem_addr; cap_be = dmem_be; cap_wdata = dmem_wdata;
            end
            if (load_valid_m) cap_rd = read_data_m;
            if (bus_error_m)  cap_berr = 1'b1;
            if (misalign_m)   cap_mis = 1'b1;
        end
    end

    task automatic set_idle_exp();
        exp_stall = 0; exp_req = 0; exp_lv = 0; exp_berr = 0; exp_mis = 0; exp_rd = rd_model;
    endtask

    task automatic idle_cycle(input bit noise);
        mem_read_m = 0; mem_write_m = 0;
        alu_out_m = $urandom; write_data_m = $urandom;
        dmem_ready  = noise && ($urandom % 2 == 1);
        dmem_rvalid = noise && ($urandom % 2 == 1);
        dmem_rdata  = $urandom;
        set_idle_exp();
        @(posedge clk); #1;
    endtask

    // Reset mid-access, then a late response that must be ignored.
    task automatic abort_with_reset(input bit req_now);
        chk_en = 0;
        chk("req_before_rst", {31'b0, dmem_req}, {31'b0, req_now});
        rst = 1'b1;
        #1;
        chk("req_in_rst", {31'b0, dmem_req}, 32'd0);
        chk("stall_in_rst", {31'b0, stall_m}, 32'd0);
        chk("lv_in_rst", {31'b0, load_valid_m}, 32'd0);
        chk("rdata_in_rst", read_data_m, 32'd0);
        mem_read_m = 0; mem_write_m = 0; dmem_ready = 0;
        rd_model = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_en = 1;
        repeat (3) begin
            mem_read_m = 0; mem_write_m = 0;
            dmem_rvalid = 1'b1; dmem_rdata = $urandom;
            set_idle_exp();
            @(posedge clk); #1;
        end
        dmem_rvalid = 0;
    endtask

    // rdly/rvdly < 0: never ready / never rvalid. abort_at >= 0: reset in that cycle.
    task automatic run_op(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdat,
                          input int rdly, input int rvdly, input int abort_at);
        int n, k, k0, a, r, d, req_last;
        bit trap, tmo, is_load;
        n  = nb(sz);
        k  = int'(addr[1:0]);
        k0 = k - (k % n);
`ifdef MEM_MISALIGN_TRAP_EN
        trap = (k % n) != 0;
`else
        trap = 1'b0;
`endif
        is_load = rd && !wr;
        tmo = 0; a = -1; r = -1; req_last = 0;
        if (trap) begin
            d = 1;
        end else if (rdly < 0 || rdly >= TMO) begin
            tmo = 1; d = TMO + 1; req_last = TMO;
        end else begin
            a = 1 + rdly; req_last = a;
            if (wr) d = a + 1;
            else begin
                r = a + 1 + ((rvdly < 0) ? TMO : rvdly);
                if (rvdly < 0 || r > TMO) begin tmo = 1; d = TMO + 1; r = -1; end
                else d = r + 1;
            end
        end
        exp_we = wr; exp_addr = addr[31:2]; exp_be = m_be(k0, n); exp_wdata = m_wdata(wd, n);
        for (int c = 0; c <= d; c++) begin
            if (c == abort_at) begin
                abort_with_reset(!trap && c >= 1 && c <= req_last);
                return;
            end
            mem_read_m = rd; mem_write_m = wr; mem_size_m = sz; mem_unsigned_m = uns;
            alu_out_m = addr; write_data_m = wd;
            dmem_ready  = (c == a) || (a >= 0 && !wr && c > a && c < d && ($urandom % 2 == 1));
            dmem_rvalid = (c == r);
            dmem_rdata  = (c == r) ? rdat : $urandom;
            if (c == d) begin
                if (tmo || trap) rd_model = '0;
                else if (is_load) rd_model = m_load(rdat, k0, n, uns);
            end
            exp_stall = (c < d);
            exp_req   = !trap && c >= 1 && c <= req_last;
            exp_lv    = (c == d) && is_load && !trap && !tmo;
            exp_berr  = (c == d) && tmo;
            exp_mis   = (c == d) && trap;
            exp_rd    = rd_model;
            @(posedge clk); #1;
        end
    endtask

    task automatic clear_caps();
        cap_req = 0; cap_berr = 0; cap_mis = 0; cap_rd = 'x; cap_be = 'x; cap_addr = 'x; cap_wdata = 'x;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        int sel;
        bit rd, wr;
        rst = 1'b1; chk_en = 0; rd_model = '0;
        mem_read_m = 0; mem_write_m = 0; mem_size_m = 0; mem_unsigned_m = 0;
        alu_out_m = 0; write_data_m = 0; dmem_ready = 0; dmem_rvalid = 0; dmem_rdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {31'b0, stall_m}, 32'd0);
        chk("rst_req", {31'b0, dmem_req}, 32'd0);
        chk("rst_we", {31'b0, dmem_we}, 32'd0);
        chk("rst_addr", {2'b0, dmem_addr}, 32'd0);
        chk("rst_be", {28'b0, dmem_be}, 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        chk("rst_rdata", read_data_m, 32'd0);
        chk("rst_pulses", {29'b0, load_valid_m, bus_error_m, misalign_m}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; chk_en = 1;
        idle_cycle(0);

        clear_caps();
        run_op(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0, -1);
        chk("sw_addr", {2'b0, cap_addr}, 32'h4);
        chk("sw_be", {28'b0, cap_be}, 32'hF);
        chk("sw_wdata", cap_wdata, 32'hDEADBEEF);

        clear_caps();
        run_op(1, 0, 2'b00, 0, 32'h13, 32'h0, 32'h80FF0000, 3, 0, -1);
        chk("lb_be", {28'b0, cap_be}, 32'h8);
        chk("lb_data", cap_rd, 32'hFFFFFF80);

        clear_caps();
        run_op(1, 0, 2'b01, 1, 32'h12, 32'h0, 32'hBEEF1234, 0, 1, -1);
        chk("lhu_data", cap_rd, 32'h0000BEEF);
        clear_caps();
        run_op(1, 0, 2'b01, 0, 32'h12, 32'h0, 32'hBEEF1234, 1, 0, -1);
        chk("lh_data", cap_rd, 32'hFFFFBEEF);

        clear_caps();
        run_op(0, 1, 2'b00, 0, 32'h01, 32'h000000A5, 32'h0, 2, 0, -1);
        chk("sb_be", {28'b0, cap_be}, 32'h2);
        chk("sb_wdata", cap_wdata, 32'hA5A5A5A5);

        clear_caps();
        run_op(1, 0, 2'b10, 0, 32'h40, 32'h0, 32'h0, -1, 0, -1);
        chk("tmo_req_berr", {31'b0, cap_berr}, 32'd1);
        idle_cycle(1);
        run_op(1, 0, 2'b10, 0, 32'h44, 32'h0, 32'h0, 2, -1, -1);
        idle_cycle(1);

        run_op(1, 0, 2'b10, 0, 32'h80, 32'h0, 32'h0, -1, 0, 3);
        run_op(1, 0, 2'b10, 0, 32'h84, 32'h0, 32'h12345678, 0, 5, 3);

        clear_caps();
`ifdef MEM_MISALIGN_TRAP_EN
        run_op(1, 0, 2'b10, 0, 32'h02, 32'h0, 32'h11223344, 0, 0, -1);
        chk("trap_mis", {31'b0, cap_mis}, 32'd1);
        chk("trap_noreq", {31'b0, cap_req}, 32'd0);
`else
        run_op(1, 0, 2'b10, 0, 32'h02, 32'h0, 32'h11223344, 0, 0, -1);
        chk("align_be", {28'b0, cap_be}, 32'hF);
        chk("align_data", cap_rd, 32'h11223344);
`endif

        for (int i = 0; i < 150; i++) begin
            sel = int'($urandom % 8);
            rd  = (sel < 4) || (sel == 7);
            wr  = (sel >= 4);
            run_op(rd, wr, 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
                   int'($urandom % 4), int'($urandom % 4), -1);
            if ($urandom % 3 == 0) idle_cycle(1);
        end
        idle_cycle(1);
        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage initiator for the MIPS pipeline.
- Accepts load/store requests from the M stage and drives a valid/ready request channel to the data memory.
- Collects read responses and returns aligned, sign- or zero-extended load data.
- Holds the pipeline with stall_m while an access is outstanding; supports byte, halfword and word accesses through byte enables.

Parameters:
ADDR_BITS, 32, width of byte address from ALU
DATA_BITS, 32, data word width (fixed 4 byte lanes)
TIMEOUT_CYCLES, 255, max cycles in REQ+WAIT before bus error

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
mem_read_m  in  1  M-stage load
mem_write_m  in  1  M-stage store
mem_size_m  in  2  00 byte, 01 half, 10 word, 11 treated as word
mem_unsigned_m  in  1  zero-extend load (lbu/lhu)
alu_out_m  in  ADDR_BITS  byte address
write_data_m  in  DATA_BITS  store data (low bytes significant)
stall_m  out  1  freeze pipeline
read_data_m  out  DATA_BITS  extended load result
load_valid_m  out  1  read_data_m valid (one cycle)
misalign_m  out  1  misaligned-access trap pulse
bus_error_m  out  1  timeout pulse
dmem_req  out  1  request valid
dmem_we  out  1  request is write
dmem_addr  out  ADDR_BITS-2  word address
dmem_be  out  4  byte enables
dmem_wdata  out  DATA_BITS  lane-replicated store data
dmem_ready  in  1  request accepted this cycle
dmem_rvalid  in  1  read response valid
dmem_rdata  in  DATA_BITS  read response word

Behaviour:
- Reset: state IDLE, timeout counter 0, all outputs 0. Reset mid-access drops dmem_req asynchronously; the access is abandoned with no completion pulse.
- States:
  - IDLE: if mem_write_m|mem_read_m, latch address/data/size/unsigned/we, go REQ. stall_m=1 combinationally in the same cycle. If both are asserted, the access is a write and no load data is returned.
  - REQ: dmem_req=1; dmem_we/addr/be/wdata stay stable until dmem_ready. On ready: write -> DONE, read -> WAIT. dmem_rvalid is never earlier than the cycle after acceptance.
  - WAIT: on dmem_rvalid, capture and extract data, go DONE.
  - DONE: stall_m=0 for exactly one cycle; the pipeline advances at this edge; load_valid_m=1 for reads. A new request is never accepted in DONE. Next state is always IDLE.
- stall_m = (IDLE & (rd|wr)) | REQ | WAIT.
- Minimum latency: accept to DONE = 2 cycles for a write with ready in REQ; 3 cycles for a read with rvalid the cycle after acceptance.
- Lane rules (little-endian, k = addr[1:0]):
  - Byte: be = 0001<<k; wdata = byte replicated ×4.
  - Half: be = 0011<<(2·addr[1]); wdata = half replicated ×2.
  - Word: be = 1111.
- Load extraction: rdata >> 8·k, truncate to size, then sign-extend, or zero-extend when unsigned. read_data_m holds its value until the next load completes.
- Timeout: counter increments in REQ/WAIT and clears in IDLE. When it reaches TIMEOUT_CYCLES: drop dmem_req, go DONE, pulse bus_error_m, read_data_m=0. A late rvalid arriving in IDLE is ignored.

Optional Feature:
MEM_MISALIGN_TRAP_EN
- Defined: a half with addr[0]=1, or a word with addr[1:0]≠0, issues no request. State goes IDLE->DONE, misalign_m pulses in DONE, read_data_m=0, load_valid_m=0.
- Undefined: offending low address bits are forced to 0 (natural alignment); misalign_m tied 0.

Decomposition:
- CPU_def package holds:
  - mem_size_t enum (MEM_BYTE, MEM_HALF, MEM_WORD)
  - mau_state_t enum (MAU_IDLE, MAU_REQ, MAU_WAIT, MAU_DONE)
  - BYTE_LANES=4
- Sub-module lane_align (combinational): addr low bits, size, unsigned, wdata/rdata -> be, replicated wdata, extended read data.

Test Plan:
- sw 0xDEADBEEF @0x10, dmem_ready in first REQ cycle -> dmem_addr=0x4, be=1111, wdata=0xDEADBEEF; stall_m high 2 cycles, low in DONE.
- lb @0x13, rdata=0x80FF0000 held 3 cycles of not-ready -> be=1000; read_data_m=0xFFFFFF80, load_valid_m one cycle after rvalid.
- lhu @0x12, rdata=0xBEEF1234 -> read_data_m=0x0000BEEF; lh same -> 0xFFFFBEEF.
- sb 0x000000A5 @0x01 -> be=0010, wdata=0xA5A5A5A5.
- Read with dmem_ready never asserted -> after 255 cycles dmem_req drops, bus_error_m pulses, read_data_m=0, stall_m releases.
- rst asserted during WAIT -> dmem_req, stall_m=0 immediately; the subsequent rvalid is ignored. With MEM_MISALIGN_TRAP_EN, lw @0x02 -> no dmem_req, misalign_m pulse.
